// File: rtl/mul_div_unit_pkg.sv
// Shared mul/div definitions: mdop encoding and HI/LO select codes.
// Imported by the decoder, the D/E register and the mul/div unit, so the
// mdop encoding has a single source.
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    MDOP_MULT  = 3'd0,
    MDOP_MULTU = 3'd1,
    MDOP_DIV   = 3'd2,
    MDOP_DIVU  = 3'd3
  } mdop_e;

  localparam logic HLSEL_LO = 1'b0;
  localparam logic HLSEL_HI = 1'b1;

  // Codes 4-7 are reserved and never start an operation.
  function automatic logic mdop_valid(input logic [2:0] op);
    return (op <= 3'd3);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Execute-stage multiply/divide unit. Holds architectural HI/LO, runs
// MULT/MULTU/DIV/DIVU over a fixed latency and serves MTHI/MTLO/MFHI/MFLO.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdstart,
  input  logic [2:0]  mdop,
  input  logic        hlwrite,
  input  logic        hlsel,
  input  logic        hlread,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hl_rdata
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);

  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [63:0]        r_pend;
  logic               r_dz;
  logic               r_busy;
  logic [CW-1:0]      r_cnt;

  logic signed [63:0] w_sprod;
  logic [63:0]        w_uprod;
  logic [31:0]        w_a_mag;
  logic [31:0]        w_b_mag;
  logic [31:0]        w_dnum;
  logic [31:0]        w_dden;
  logic [31:0]        w_quo;
  logic [31:0]        w_rem;
  logic [31:0]        w_squo;
  logic [31:0]        w_srem;
  logic               w_is_div;
  logic               w_b_zero;
  logic [63:0]        w_result;

  assign w_sprod  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_uprod  = {32'd0, a} * {32'd0, b};
  assign w_b_zero = (b == '0);

  // Signed division runs on magnitudes through the one divider and fixes the
  // signs afterwards; this also yields 0x80000000 / -1 = 0x80000000 rem 0
  // without a special case, since |0x80000000| is representable unsigned.
  always_comb begin
    w_a_mag = a[31] ? (~a + 32'd1) : a;
    w_b_mag = b[31] ? (~b + 32'd1) : b;
    if (mdop == MDOP_DIVU) begin
      w_dnum = a;
      w_dden = b;
    end else begin
      w_dnum = w_a_mag;
      w_dden = w_b_mag;
    end
    if (w_b_zero) begin
      w_quo = '0;
      w_rem = '0;
    end else begin
      w_quo = w_dnum / w_dden;
      w_rem = w_dnum % w_dden;
    end
    w_squo = (a[31] ^ b[31]) ? (~w_quo + 32'd1) : w_quo;
    w_srem = a[31] ? (~w_rem + 32'd1) : w_rem;
  end

  // Select the pending {hi,lo} result for the requested operation.
  always_comb begin
    w_result = '0;
    w_is_div = 1'b0;
    case (mdop)
      MDOP_MULT:  w_result = w_sprod;
      MDOP_MULTU: w_result = w_uprod;
      MDOP_DIV: begin
        w_result = {w_srem, w_squo};
        w_is_div = 1'b1;
      end
      MDOP_DIVU: begin
        w_result = {w_rem, w_quo};
        w_is_div = 1'b1;
      end
      default: begin
        w_result = '0;
        w_is_div = 1'b0;
      end
    endcase
  end

  // Accept, count down and commit operations; serve MTHI/MTLO when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_pend <= '0;
      r_dz   <= 1'b0;
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (r_busy) begin
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
        if (!r_dz) begin
          r_hi <= r_pend[63:32];
          r_lo <= r_pend[31:0];
        end
      end
      r_cnt <= r_cnt - CW'(1);
    end else if (mdstart) begin
      if (mdop_valid(mdop)) begin
        r_busy <= 1'b1;
        r_cnt  <= w_is_div ? DIV_N : MUL_N;
        r_pend <= w_result;
        r_dz   <= w_is_div && w_b_zero;
      end
    end else if (hlwrite) begin
      if (hlsel == HLSEL_HI) begin
        r_hi <= a;
      end else begin
        r_lo <= a;
      end
    end
  end

  assign busy = r_busy;

  // Committed HI/LO read port, zero when not reading.
  always_comb begin
    hl_rdata = '0;
    if (hlread) begin
      hl_rdata = (hlsel == HLSEL_HI) ? r_hi : r_lo;
    end
  end

endmodule
